// File: rtl/assoc_cache_pkg.sv
// assoc_cache_pkg: shared types and helpers for the fully associative cache.
// FSM state encoding, bus direction constants and a width helper for the age field.
package assoc_cache_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWb   = 2'd1,
    StFill = 2'd2,
    StWt   = 2'd3
  } state_e;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // Ceiling log2, used to size the age field (ENTRIES is a power of two).
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/assoc_cache_if.sv
// assoc_cache_if: CPU-side and memory-side buses of the cache.
// The slave modport is the cache itself; master is the CPU/memory environment.
interface assoc_cache_if #(
  parameter int unsigned D_WIDTH = 8,
  parameter int unsigned A_WIDTH = 8
);

  logic               cpu_req;
  logic               cpu_rw;
  logic [A_WIDTH-1:0] cpu_addr;
  logic [D_WIDTH-1:0] cpu_wdata;
  logic [D_WIDTH-1:0] cpu_rdata;
  logic               cpu_ready;
  logic               cpu_busy;

  logic               mem_req;
  logic               mem_rw;
  logic [A_WIDTH-1:0] mem_addr;
  logic [D_WIDTH-1:0] mem_wdata;
  logic [D_WIDTH-1:0] mem_rdata;
  logic               mem_ack;

  modport slave (
    input  cpu_req, cpu_rw, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
    output cpu_rdata, cpu_ready, cpu_busy, mem_req, mem_rw, mem_addr, mem_wdata
  );

  modport master (
    output cpu_req, cpu_rw, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
    input  cpu_rdata, cpu_ready, cpu_busy, mem_req, mem_rw, mem_addr, mem_wdata
  );

endinterface

// File: rtl/cache_lookup.sv
// cache_lookup: combinational tag match, victim choice and LRU decrement mask.
// Inputs are the flattened per-entry address, valid and age vectors.
module cache_lookup
  import assoc_cache_pkg::*;
#(
  parameter int unsigned A_WIDTH = 8,
  parameter int unsigned ENTRIES = 4,
  parameter int unsigned AGE_W   = clog2(ENTRIES)
) (
  input  logic [ENTRIES*A_WIDTH-1:0] addr_flat,
  input  logic [ENTRIES-1:0]         valid,
  input  logic [ENTRIES*AGE_W-1:0]   age_flat,
  input  logic [A_WIDTH-1:0]         lookup_addr,
  input  logic [AGE_W-1:0]           touch_idx,
  output logic                       hit,
  output logic [AGE_W-1:0]           hit_idx,
  output logic [AGE_W-1:0]           victim_idx,
  output logic [ENTRIES-1:0]         dec_mask
);

  logic             any_inv;
  logic [AGE_W-1:0] vic_inv;
  logic [AGE_W-1:0] vic_lru;
  logic [AGE_W-1:0] touch_age;

  // Tag compare; valid entries hold distinct addresses so at most one matches.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (valid[i] && (addr_flat[i*A_WIDTH +: A_WIDTH] == lookup_addr)) begin
        hit     = 1'b1;
        hit_idx = AGE_W'(i);
      end
    end
  end

  // Victim: lowest-index invalid entry, otherwise the entry whose age is 0.
  always_comb begin
    any_inv = 1'b0;
    vic_inv = '0;
    vic_lru = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (age_flat[i*AGE_W +: AGE_W] == '0) vic_lru = AGE_W'(i);
    end
    // Descending scan so the lowest invalid index wins.
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        any_inv = 1'b1;
        vic_inv = AGE_W'(i);
      end
    end
    victim_idx = any_inv ? vic_inv : vic_lru;
  end

  // Entries older-ranked than the touched one (larger age) step down by one.
  always_comb begin
    touch_age = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (touch_idx == AGE_W'(i)) touch_age = age_flat[i*AGE_W +: AGE_W];
    end
    for (int i = 0; i < ENTRIES; i++) begin
      dec_mask[i] = (age_flat[i*AGE_W +: AGE_W] > touch_age);
    end
  end

endmodule

// File: rtl/assoc_cache.sv
// assoc_cache: fully associative, single-word-line cache with true-LRU replacement.
// Define ASSOC_CACHE_WB_EN for write-back (dirty bits, WB state); otherwise write-through.
module assoc_cache
  import assoc_cache_pkg::*;
#(
  parameter int unsigned D_WIDTH = 8,
  parameter int unsigned A_WIDTH = 8,
  parameter int unsigned ENTRIES = 4
) (
  input logic          clk,
  input logic          clr,
  assoc_cache_if.slave bus
);

  localparam int unsigned      AGE_W   = clog2(ENTRIES);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(ENTRIES - 1);

  state_e                          state_q, state_d;
  logic [ENTRIES-1:0]              valid_q, valid_d;
  logic [ENTRIES-1:0][A_WIDTH-1:0] addr_q, addr_d;
  logic [ENTRIES-1:0][D_WIDTH-1:0] data_q, data_d;
  logic [ENTRIES-1:0][AGE_W-1:0]   age_q, age_d;
`ifdef ASSOC_CACHE_WB_EN
  logic [ENTRIES-1:0]              dirty_q, dirty_d;
  logic                            victim_dirty;
`endif

  // Request captured at acceptance, plus the entry it will land in.
  logic [A_WIDTH-1:0] lat_addr_q, lat_addr_d;
  logic [D_WIDTH-1:0] lat_data_q, lat_data_d;
  logic               lat_rw_q, lat_rw_d;
  logic [AGE_W-1:0]   vic_q, vic_d;

  logic [D_WIDTH-1:0] rdata_q, rdata_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;
  logic               mem_req_q, mem_req_d;
  logic               mem_rw_q, mem_rw_d;
  logic [A_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [D_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

  logic               accept;
  logic               hit;
  logic               touch;
  logic [AGE_W-1:0]   hit_idx;
  logic [AGE_W-1:0]   victim_idx;
  logic [AGE_W-1:0]   touch_idx;
  logic [ENTRIES-1:0] dec_mask;

  assign accept = bus.cpu_req & ~busy_q & (state_q == StIdle);

`ifdef ASSOC_CACHE_WB_EN
  assign victim_dirty = valid_q[victim_idx] & dirty_q[victim_idx];
`endif

  cache_lookup #(
    .A_WIDTH(A_WIDTH),
    .ENTRIES(ENTRIES),
    .AGE_W  (AGE_W)
  ) u_lookup (
    .addr_flat  (addr_q),
    .valid      (valid_q),
    .age_flat   (age_q),
    .lookup_addr(bus.cpu_addr),
    .touch_idx  (touch_idx),
    .hit        (hit),
    .hit_idx    (hit_idx),
    .victim_idx (victim_idx),
    .dec_mask   (dec_mask)
  );

  // Entry to touch: the hit or fresh victim while idle, the latched victim otherwise.
  always_comb begin
    if (state_q != StIdle) touch_idx = vic_q;
    else if (hit)          touch_idx = hit_idx;
    else                   touch_idx = victim_idx;
  end

  // Next-state, entry updates and registered outputs.
  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    addr_d      = addr_q;
    data_d      = data_q;
    age_d       = age_q;
`ifdef ASSOC_CACHE_WB_EN
    dirty_d     = dirty_q;
`endif
    lat_addr_d  = lat_addr_q;
    lat_data_d  = lat_data_q;
    lat_rw_d    = lat_rw_q;
    vic_d       = vic_q;
    rdata_d     = rdata_q;
    ready_d     = 1'b0;
    busy_d      = busy_q;
    mem_req_d   = mem_req_q;
    mem_rw_d    = mem_rw_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    touch       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          lat_addr_d = bus.cpu_addr;
          lat_data_d = bus.cpu_wdata;
          lat_rw_d   = bus.cpu_rw;
          vic_d      = victim_idx;
          if (hit) begin
            touch = 1'b1;
            if (bus.cpu_rw == RW_READ) begin
              rdata_d = data_q[hit_idx];
              ready_d = 1'b1;
            end else begin
              data_d[hit_idx] = bus.cpu_wdata;
`ifdef ASSOC_CACHE_WB_EN
              dirty_d[hit_idx] = 1'b1;
              ready_d          = 1'b1;
`else
              state_d = StWt;
              busy_d  = 1'b1;
`endif
            end
          end else if (bus.cpu_rw == RW_READ) begin
            busy_d = 1'b1;
`ifdef ASSOC_CACHE_WB_EN
            state_d = victim_dirty ? StWb : StFill;
`else
            state_d = StFill;
`endif
          end else begin
`ifdef ASSOC_CACHE_WB_EN
            if (victim_dirty) begin
              // Install is deferred until the old line has been written out.
              state_d = StWb;
              busy_d  = 1'b1;
            end else begin
              valid_d[victim_idx] = 1'b1;
              addr_d[victim_idx]  = bus.cpu_addr;
              data_d[victim_idx]  = bus.cpu_wdata;
              dirty_d[victim_idx] = 1'b1;
              touch               = 1'b1;
              ready_d             = 1'b1;
            end
`else
            valid_d[victim_idx] = 1'b1;
            addr_d[victim_idx]  = bus.cpu_addr;
            data_d[victim_idx]  = bus.cpu_wdata;
            touch               = 1'b1;
            state_d             = StWt;
            busy_d              = 1'b1;
`endif
          end
        end
      end

      StWb: begin
        if (!mem_req_q) begin
          mem_req_d   = 1'b1;
          mem_rw_d    = RW_WRITE;
          mem_addr_d  = addr_q[vic_q];
          mem_wdata_d = data_q[vic_q];
        end else if (bus.mem_ack) begin
          mem_req_d = 1'b0;
          if (lat_rw_q == RW_READ) begin
            state_d = StFill;
          end else begin
            valid_d[vic_q] = 1'b1;
            addr_d[vic_q]  = lat_addr_q;
            data_d[vic_q]  = lat_data_q;
`ifdef ASSOC_CACHE_WB_EN
            dirty_d[vic_q] = 1'b1;
`endif
            touch   = 1'b1;
            ready_d = 1'b1;
            busy_d  = 1'b0;
            state_d = StIdle;
          end
        end
      end

      StFill: begin
        if (!mem_req_q) begin
          mem_req_d  = 1'b1;
          mem_rw_d   = RW_READ;
          mem_addr_d = lat_addr_q;
        end else if (bus.mem_ack) begin
          mem_req_d      = 1'b0;
          valid_d[vic_q] = 1'b1;
          addr_d[vic_q]  = lat_addr_q;
          data_d[vic_q]  = bus.mem_rdata;
`ifdef ASSOC_CACHE_WB_EN
          dirty_d[vic_q] = 1'b0;
`endif
          touch   = 1'b1;
          rdata_d = bus.mem_rdata;
          ready_d = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end

      StWt: begin
        if (!mem_req_q) begin
          mem_req_d   = 1'b1;
          mem_rw_d    = RW_WRITE;
          mem_addr_d  = lat_addr_q;
          mem_wdata_d = lat_data_q;
        end else if (bus.mem_ack) begin
          mem_req_d = 1'b0;
          ready_d   = 1'b1;
          busy_d    = 1'b0;
          state_d   = StIdle;
        end
      end
    endcase

    // LRU touch keeps the ages a permutation of 0..ENTRIES-1.
    if (touch) begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (dec_mask[i]) age_d[i] = age_q[i] - 1'b1;
      end
      age_d[touch_idx] = AGE_MAX;
    end
  end

  // State and output registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q     <= StIdle;
      valid_q     <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      for (int i = 0; i < ENTRIES; i++) age_q[i] <= AGE_W'(i);
`ifdef ASSOC_CACHE_WB_EN
      dirty_q     <= '0;
`endif
      lat_addr_q  <= '0;
      lat_data_q  <= '0;
      lat_rw_q    <= 1'b0;
      vic_q       <= '0;
      rdata_q     <= '0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_rw_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      age_q       <= age_d;
`ifdef ASSOC_CACHE_WB_EN
      dirty_q     <= dirty_d;
`endif
      lat_addr_q  <= lat_addr_d;
      lat_data_q  <= lat_data_d;
      lat_rw_q    <= lat_rw_d;
      vic_q       <= vic_d;
      rdata_q     <= rdata_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      mem_req_q   <= mem_req_d;
      mem_rw_q    <= mem_rw_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign bus.cpu_rdata = rdata_q;
  assign bus.cpu_ready = ready_q;
  assign bus.cpu_busy  = busy_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_rw    = mem_rw_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule
